// File: rtl/frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : frame_transmitter
// Brief    : Byte-wide frame transmitter: 0x55 preamble, SFD 0xD5, payload,
//            optional CRC-32 FCS (macro TX_FCS_EN), then inter-frame gap.
// Revision : 1.0 - initial release
// ============================================================================
module frame_transmitter #(
    parameter int DATA_WIDTH   = 8,
    parameter int PREAMBLE_LEN = 7,
    parameter int IFG_CYCLES   = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] payload_byte,
    input  logic                  payload_valid,
    input  logic                  payload_last,
    output logic                  payload_ready,
    output logic [DATA_WIDTH-1:0] tx_byte,
    output logic                  tx_byte_valid,
    output logic                  tx_busy,
    output logic                  frame_sent,
    output logic                  tx_underrun
);

    localparam int                    c_IFG_W         = (IFG_CYCLES < 2) ? 1 : $clog2(IFG_CYCLES);
    localparam logic [2:0]            c_PRE_LOAD      = 3'(PREAMBLE_LEN - 1);
    localparam logic [c_IFG_W-1:0]    c_IFG_LOAD      = c_IFG_W'(IFG_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] c_PREAMBLE_BYTE = DATA_WIDTH'(8'h55);
    localparam logic [DATA_WIDTH-1:0] c_SFD_BYTE      = DATA_WIDTH'(8'hD5);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_SFD      = 3'd2,
        S_PAYLOAD  = 3'd3,
`ifdef TX_FCS_EN
        S_FCS      = 3'd5,
`endif
        S_IFG      = 3'd4
    } state_t;

    state_t                r_state,    w_state_nxt;
    logic [DATA_WIDTH-1:0] r_tx_byte,  w_tx_byte_nxt;
    logic                  r_tx_valid, w_tx_valid_nxt;
    logic                  r_ready,    w_ready_nxt;
    logic                  r_busy,     w_busy_nxt;
    logic                  r_sent,     w_sent_nxt;
    logic                  r_under,    w_under_nxt;
    logic                  r_last,     w_last_nxt;
    logic [2:0]            r_pre_cnt,  w_pre_cnt_nxt;
    logic [c_IFG_W-1:0]    r_ifg_cnt,  w_ifg_cnt_nxt;

`ifdef TX_FCS_EN
    logic [31:0] r_crc, w_crc_nxt;
    logic [1:0]  r_fcs_idx, w_fcs_idx_nxt;
    logic [31:0] w_fcs;
    logic [31:0] w_fcs_shift;

    // Reflected CRC-32, one byte, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ data[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    assign w_fcs       = ~r_crc;
    assign w_fcs_shift = w_fcs >> {r_fcs_idx + 2'd1, 3'b000};
`endif

    always_comb begin
        w_state_nxt    = r_state;
        w_tx_byte_nxt  = '0;
        w_tx_valid_nxt = 1'b0;
        w_ready_nxt    = 1'b0;
        w_sent_nxt     = 1'b0;
        w_under_nxt    = 1'b0;
        w_last_nxt     = r_last;
        w_pre_cnt_nxt  = r_pre_cnt;
        w_ifg_cnt_nxt  = r_ifg_cnt;
`ifdef TX_FCS_EN
        w_crc_nxt      = r_crc;
        w_fcs_idx_nxt  = r_fcs_idx;
`endif
        case (r_state)
            S_IDLE: begin
                if (payload_valid) begin
                    w_state_nxt    = S_PREAMBLE;
                    w_tx_byte_nxt  = c_PREAMBLE_BYTE;
                    w_tx_valid_nxt = 1'b1;
                    w_pre_cnt_nxt  = c_PRE_LOAD;
                    w_last_nxt     = 1'b0;
`ifdef TX_FCS_EN
                    w_crc_nxt      = 32'hFFFF_FFFF;
`endif
                end
            end
            S_PREAMBLE: begin
                w_tx_valid_nxt = 1'b1;
                if (r_pre_cnt == 3'd0) begin
                    w_state_nxt   = S_SFD;
                    w_tx_byte_nxt = c_SFD_BYTE;
                    w_ready_nxt   = 1'b1;
                end else begin
                    w_pre_cnt_nxt = r_pre_cnt - 3'd1;
                    w_tx_byte_nxt = c_PREAMBLE_BYTE;
                end
            end
            S_SFD, S_PAYLOAD: begin
                if (r_state == S_PAYLOAD && r_last) begin
                    // Final payload byte is on the line; close the frame
`ifdef TX_FCS_EN
                    w_state_nxt    = S_FCS;
                    w_tx_byte_nxt  = w_fcs[7:0];
                    w_tx_valid_nxt = 1'b1;
                    w_fcs_idx_nxt  = 2'd0;
`else
                    w_state_nxt    = S_IFG;
                    w_sent_nxt     = 1'b1;
                    w_ifg_cnt_nxt  = c_IFG_LOAD;
`endif
                end else if (payload_valid) begin
                    w_state_nxt    = S_PAYLOAD;
                    w_tx_byte_nxt  = payload_byte;
                    w_tx_valid_nxt = 1'b1;
                    w_last_nxt     = payload_last;
                    w_ready_nxt    = !payload_last;
`ifdef TX_FCS_EN
                    w_crc_nxt      = crc32_byte(r_crc, payload_byte[7:0]);
`endif
                end else begin
                    w_state_nxt   = S_IFG;
                    w_under_nxt   = 1'b1;
                    w_ifg_cnt_nxt = c_IFG_LOAD;
                end
            end
`ifdef TX_FCS_EN
            S_FCS: begin
                if (r_fcs_idx == 2'd3) begin
                    w_state_nxt   = S_IFG;
                    w_sent_nxt    = 1'b1;
                    w_ifg_cnt_nxt = c_IFG_LOAD;
                end else begin
                    w_tx_byte_nxt  = w_fcs_shift[7:0];
                    w_tx_valid_nxt = 1'b1;
                    w_fcs_idx_nxt  = r_fcs_idx + 2'd1;
                end
            end
`endif
            S_IFG: begin
                if (r_ifg_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ifg_cnt_nxt = r_ifg_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tx_byte  <= '0;
            r_tx_valid <= 1'b0;
            r_ready    <= 1'b0;
            r_busy     <= 1'b0;
            r_sent     <= 1'b0;
            r_under    <= 1'b0;
            r_last     <= 1'b0;
            r_pre_cnt  <= '0;
            r_ifg_cnt  <= '0;
`ifdef TX_FCS_EN
            r_crc      <= 32'hFFFF_FFFF;
            r_fcs_idx  <= 2'd0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_tx_byte  <= w_tx_byte_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_ready    <= w_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_sent     <= w_sent_nxt;
            r_under    <= w_under_nxt;
            r_last     <= w_last_nxt;
            r_pre_cnt  <= w_pre_cnt_nxt;
            r_ifg_cnt  <= w_ifg_cnt_nxt;
`ifdef TX_FCS_EN
            r_crc      <= w_crc_nxt;
            r_fcs_idx  <= w_fcs_idx_nxt;
`endif
        end
    end

    assign payload_ready = r_ready;
    assign tx_byte       = r_tx_byte;
    assign tx_byte_valid = r_tx_valid;
    assign tx_busy       = r_busy;
    assign frame_sent    = r_sent;
    assign tx_underrun   = r_under;

endmodule
`default_nettype wire

// File: tb/tb_frame_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_transmitter
// Brief    : Directed self-checking bench for frame_transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_transmitter;

    typedef logic [7:0] byte_t;

    logic       clk = 1'b0;
    logic       rst_n;
    byte_t      payload_byte;
    logic       payload_valid;
    logic       payload_last;
    logic       payload_ready;
    byte_t      tx_byte;
    logic       tx_byte_valid;
    logic       tx_busy;
    logic       frame_sent;
    logic       tx_underrun;

    int n_checks = 0;
    int n_pass   = 0;

    byte_t q_pay[$];
    byte_t q_fcs[$];

`ifdef TX_FCS_EN
    localparam int NFCS = 4;
`else
    localparam int NFCS = 0;
`endif

    always #5 clk = ~clk;

    frame_transmitter #(
        .DATA_WIDTH   (8),
        .PREAMBLE_LEN (7),
        .IFG_CYCLES   (12)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .payload_byte  (payload_byte),
        .payload_valid (payload_valid),
        .payload_last  (payload_last),
        .payload_ready (payload_ready),
        .tx_byte       (tx_byte),
        .tx_byte_valid (tx_byte_valid),
        .tx_busy       (tx_busy),
        .frame_sent    (frame_sent),
        .tx_underrun   (tx_underrun)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // {busy, ready, frame_sent, underrun, valid, byte}
    function automatic logic [31:0] pack(input logic busy, input logic rdy, input logic fs,
                                         input logic ur, input logic v, input byte_t b);
        return {19'b0, busy, rdy, fs, ur, v, b};
    endfunction

    function automatic logic [31:0] obs();
        return pack(tx_busy, payload_ready, frame_sent, tx_underrun, tx_byte_valid, tx_byte);
    endfunction

    // Inputs for rising edge c of a frame; edge 0 is the start request, edge 8 the first accept
    task automatic drive(input int c, input int n, input bit ur);
        if (c < 8) begin
            payload_valid = 1'b1;
            payload_byte  = (n > 0) ? q_pay[0] : 8'hEE;
            payload_last  = 1'b0;
        end else if (c - 8 < n) begin
            payload_valid = 1'b1;
            payload_byte  = q_pay[c-8];
            payload_last  = ((c - 8) == n - 1) && !ur;
        end else begin
            payload_valid = 1'b0;
            payload_byte  = 8'h00;
            payload_last  = 1'b0;
        end
    endtask

    function automatic byte_t line_byte(input int c, input int n);
        if (c < 7)          return 8'h55;
        else if (c == 7)    return 8'hD5;
        else if (c < 8 + n) return q_pay[c-8];
        else                return q_fcs[c-8-n];
    endfunction

    task automatic run_frame(input string name, input bit ur);
        int n, len;
        logic v, rdy, fs, u, busy;
        byte_t b;
        n   = q_pay.size();
        len = 8 + n + (ur ? 0 : q_fcs.size());
        for (int c = 0; c <= len + 12; c++) begin
            drive(c, n, ur);
            @(posedge clk);
            @(negedge clk);
            v    = (c < len);
            rdy  = (c >= 7) && (c < (ur ? 8 + n : 7 + n));
            fs   = !ur && (c == len);
            u    = ur && (c == len);
            busy = (c < len + 12);
            b    = v ? line_byte(c, n) : 8'h00;
            check($sformatf("%s c%0d", name, c), obs(), pack(busy, rdy, fs, u, v, b));
        end
        payload_valid = 1'b0;
        payload_last  = 1'b0;
        payload_byte  = 8'h00;
    endtask

    task automatic run_back_to_back();
        int    l1, f2;
        logic  v, rdy, busy, fs;
        byte_t b;
        logic [31:0] mask;
        l1 = 8 + 1 + NFCS;
        for (int c = 0; c <= l1 + 21; c++) begin
            payload_valid = 1'b1;
            payload_last  = 1'b1;
            payload_byte  = (c <= 8) ? 8'h11 : 8'h22;
            @(posedge clk);
            @(negedge clk);
            f2   = c - (l1 + 13);
            v    = (c < l1) || (f2 >= 0);
            rdy  = (c == 7) || (f2 == 7);
            busy = (c != l1 + 12);
            fs   = (c == l1);
            mask = 32'h1FFF;
            b    = 8'h00;
            if (c < 7 || (f2 >= 0 && f2 < 7)) b = 8'h55;
            else if (c == 7 || f2 == 7)       b = 8'hD5;
            else if (c == 8)                  b = 8'h11;
            else if (f2 == 8)                 b = 8'h22;
            else if (c < l1)                  mask = 32'h1F00;
            check($sformatf("b2b c%0d", c), obs() & mask, pack(busy, rdy, fs, 1'b0, v, b) & mask);
        end
        payload_valid = 1'b0;
        payload_last  = 1'b0;
        payload_byte  = 8'h00;
        repeat (30) @(negedge clk);
        check("b2b idle", obs(), 32'h0);
    endtask

    task automatic load_crc9();
        q_pay = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        q_fcs.delete();
`ifdef TX_FCS_EN
        q_fcs = '{8'h26, 8'h39, 8'hF4, 8'hCB};
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        payload_valid = 1'b0;
        payload_last  = 1'b0;
        payload_byte  = 8'h00;
        repeat (3) @(negedge clk);
        check("reset state", obs(), 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle after reset", obs(), 32'h0);

`ifndef TX_FCS_EN
        q_pay = '{8'h01, 8'h02, 8'h03};
        q_fcs.delete();
        run_frame("basic", 1'b0);
`endif
        load_crc9();
        run_frame("crc9", 1'b0);

        q_pay = '{8'hAA};
        run_frame("underrun", 1'b1);

        q_pay.delete();
        run_frame("underrun_first", 1'b1);

        run_back_to_back();

        load_crc9();
        for (int c = 0; c <= 10; c++) begin
            drive(c, 9, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        check("pre-reset accepting", obs(), pack(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h33));
        #2 rst_n = 1'b0;
        #1 check("async reset clear", obs(), 32'h0);
        @(negedge clk);
        check("reset held", obs(), 32'h0);
        payload_valid = 1'b0;
        payload_last  = 1'b0;
        rst_n         = 1'b1;
        @(negedge clk);
        check("idle after mid reset", obs(), 32'h0);
        run_frame("after_reset", 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
